// File: rtl/imm_gen_pipe_if.sv
// Handshake/payload bundle between an instruction producer, imm_gen_pipe and its result consumer.
// The master side drives instructions and out_ready_i; the slave side is the decoder.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] imm_o;
  logic [2:0]      fmt_o;

  modport master (
    output in_valid_i, instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, fmt_o
  );

  modport slave (
    input  in_valid_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, fmt_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate decoder feeding a small result FIFO (DEPTH entries, latency 1 when empty).
// Optional IMM_GEN_ILLEGAL_EN adds illegal_o, flagging unknown opcodes or non-32-bit encodings.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic flush_i,
  imm_gen_pipe_if.slave bus
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic illegal_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic            is_shift;
  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
`ifdef IMM_GEN_ILLEGAL_EN
  logic            dec_illegal;
`endif

  assign instr    = bus.instr_i;
  assign opcode   = instr[6:0];
  assign is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);

  // Sized casts of signed operands sign-extend from instr[31] up to XLEN-1.
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_imm = '0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(instr[31:20]));
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          dec_imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'($signed(instr[31:20]));
        end
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_fmt = FMT_SHAMT;
            dec_imm = XLEN'(instr[24:20]);
          end else begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'($signed(instr[31:20]));
          end
        end
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({instr[31:12], 12'h000}));
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      default: ;
    endcase
`ifdef IMM_GEN_ILLEGAL_EN
    dec_illegal = (dec_fmt == FMT_NONE) || (instr[1:0] != 2'b11);
    if (dec_illegal) begin
      dec_fmt = FMT_NONE;
      dec_imm = '0;
    end
`endif
  end

  logic [XLEN-1:0] imm_mem_q [DEPTH];
  logic [2:0]      fmt_mem_q [DEPTH];
`ifdef IMM_GEN_ILLEGAL_EN
  logic            ill_mem_q [DEPTH];
`endif

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic             not_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_empty      = (count_q != '0);
  assign bus.in_ready_o = (count_q < CNT_W'(DEPTH));
  assign bus.out_valid_o = not_empty;
  assign bus.imm_o      = not_empty ? imm_mem_q[rd_ptr_q] : '0;
  assign bus.fmt_o      = not_empty ? fmt_mem_q[rd_ptr_q] : 3'd0;
`ifdef IMM_GEN_ILLEGAL_EN
  assign illegal_o      = not_empty && ill_mem_q[rd_ptr_q];
`endif

  // A flush cancels both the push and the pop of its cycle.
  assign push = bus.in_valid_i && bus.in_ready_o && !flush_i;
  assign pop  = not_empty && bus.out_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: outputs are masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      imm_mem_q[wr_ptr_q] <= dec_imm;
      fmt_mem_q[wr_ptr_q] <= dec_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
      ill_mem_q[wr_ptr_q] <= dec_illegal;
`endif
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: an XLEN=32 and an XLEN=64 instance (DEPTH=2) share one stimulus stream,
// each output compared against hand-computed immediates and formats.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64)) if64 ();

  assign if32.in_valid_i  = in_valid;
  assign if32.instr_i     = instr;
  assign if32.out_ready_i = out_ready;
  assign if64.in_valid_i  = in_valid;
  assign if64.instr_i     = instr;
  assign if64.out_ready_i = out_ready;

`ifdef IMM_GEN_ILLEGAL_EN
  logic ill32;
  logic ill64;
`endif

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (if32)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal_o (ill32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (if64)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal_o (ill64)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] e32, input logic [2:0] f32,
                            input logic [63:0] e64, input logic [2:0] f64);
    check({tag, "_vld32"}, 64'(if32.out_valid_o), 64'(v));
    check({tag, "_vld64"}, 64'(if64.out_valid_o), 64'(v));
    check({tag, "_imm32"}, 64'(if32.imm_o), 64'(e32));
    check({tag, "_fmt32"}, 64'(if32.fmt_o), 64'(f32));
    check({tag, "_imm64"}, if64.imm_o, e64);
    check({tag, "_fmt64"}, 64'(if64.fmt_o), 64'(f64));
  endtask

  // One instruction through an otherwise idle pipe with the consumer always ready.
  task automatic send_one(input string tag, input logic [31:0] ins, input logic [31:0] e32, input logic [2:0] f32,
                          input logic [63:0] e64, input logic [2:0] f64);
    @(negedge clk);
    instr     = ins;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, "_rdy32"}, 64'(if32.in_ready_o), 64'd1);
    check({tag, "_rdy64"}, 64'(if64.in_ready_o), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_head(tag, 1'b1, e32, f32, e64, f64);
`ifdef IMM_GEN_ILLEGAL_EN
    check({tag, "_ill32"}, 64'(ill32), 64'(f32 == 3'd0));
    check({tag, "_ill64"}, 64'(ill64), 64'(f64 == 3'd0));
`endif
    $display("txn %s instr=%h imm32=%h fmt32=%0d imm64=%h fmt64=%0d",
             tag, ins, if32.imm_o, if32.fmt_o, if64.imm_o, if64.fmt_o);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'h0;
    out_ready = 1'b0;
    #1;
    check("rst_rdy32", 64'(if32.in_ready_o), 64'd1);
    check("rst_rdy64", 64'(if64.in_ready_o), 64'd1);
    check_head("rst", 1'b0, 32'h0, 3'd0, 64'h0, 3'd0);
`ifdef IMM_GEN_ILLEGAL_EN
    check("rst_ill32", 64'(ill32), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    send_one("addi_m1", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    send_one("beq_m4",  32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3);
    send_one("jal_neg", 32'h800000EF, 32'hFFF00000, 3'd5, 64'hFFFFFFFFFFF00000, 3'd5);
    send_one("slli_63", 32'h03F01093, 32'h0000001F, 3'd6, 64'h000000000000003F, 3'd6);
    send_one("lui_neg", 32'h800002B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4);
    send_one("sw_m8",   32'hFE112C23, 32'hFFFFFFF8, 3'd2, 64'hFFFFFFFFFFFFFFF8, 3'd2);
    send_one("addiw",   32'h0010809B, 32'h00000000, 3'd0, 64'h0000000000000001, 3'd1);
    send_one("slliw",   32'h0250109B, 32'h00000000, 3'd0, 64'h0000000000000005, 3'd6);
    send_one("bad_opc", 32'h0000007F, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0);
    send_one("bad_len", 32'hFFF00090, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0);
    send_one("jalr_pos", 32'h7FF08067, 32'h000007FF, 3'd1, 64'h00000000000007FF, 3'd1);
    send_one("srai_3",  32'h4030D093, 32'h00000003, 3'd6, 64'h0000000000000003, 3'd6);
    send_one("auipc",   32'h12345097, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4);
    @(posedge clk);
    #1;
    check_head("drained", 1'b0, 32'h0, 3'd0, 64'h0, 3'd0);

    // Back-pressure: two accepted, third held until the first pop frees a slot.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFFF00093;
    @(posedge clk);
    #1;
    instr = 32'hFE000EE3;
    @(posedge clk);
    #1;
    instr = 32'h800000EF;
    check("bp_full_rdy32", 64'(if32.in_ready_o), 64'd0);
    check("bp_full_rdy64", 64'(if64.in_ready_o), 64'd0);
    check_head("bp_headA", 1'b1, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_rdy32", 64'(if32.in_ready_o), 64'd0);
    check_head("bp_stable", 1'b1, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_pop_rdy32", 64'(if32.in_ready_o), 64'd1);
    check("bp_pop_rdy64", 64'(if64.in_ready_o), 64'd1);
    check_head("bp_headB", 1'b1, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_head("bp_headC", 1'b1, 32'hFFF00000, 3'd5, 64'hFFFFFFFFFFF00000, 3'd5);
    @(posedge clk);
    #1;
    check_head("bp_empty", 1'b0, 32'h0, 3'd0, 64'h0, 3'd0);
    $display("txn backpressure three-deep done");

    // Flush with a full FIFO and a pending instruction.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFFF00093;
    @(posedge clk);
    #1;
    instr = 32'hFE000EE3;
    @(posedge clk);
    #1;
    flush = 1'b1;
    instr = 32'h800000EF;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_head("flush_full", 1'b0, 32'h0, 3'd0, 64'h0, 3'd0);
    check("flush_full_rdy32", 64'(if32.in_ready_o), 64'd1);
    $display("txn flush with full fifo done");

    // Flush while ready: the instruction presented in the flush cycle must vanish.
    in_valid = 1'b1;
    instr    = 32'hFFF00093;
    @(posedge clk);
    #1;
    flush = 1'b1;
    instr = 32'h800000EF;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_head("flush_drop", 1'b0, 32'h0, 3'd0, 64'h0, 3'd0);
    @(posedge clk);
    #1;
    check_head("flush_gone", 1'b0, 32'h0, 3'd0, 64'h0, 3'd0);
    $display("txn flush drops presented instruction done");

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1;
    instr    = 32'h800002B7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_head("prerst", 1'b1, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_head("async_rst", 1'b0, 32'h0, 3'd0, 64'h0, 3'd0);
    check("async_rst_rdy32", 64'(if32.in_ready_o), 64'd1);
`ifdef IMM_GEN_ILLEGAL_EN
    check("async_rst_ill64", 64'(ill64), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_head("post_rst", 1'b0, 32'h0, 3'd0, 64'h0, 3'd0);
    $display("txn async reset mid-stream done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter DEPTH, default 2, result-FIFO entries; legal range 1..8.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 flush_i  input  1  synchronous discard of all queued results.
REQ-006 in_valid_i  input  1  instr_i holds an instruction to decode.
REQ-007 in_ready_o  output  1  block can accept an instruction this cycle.
REQ-008 instr_i  input  32  raw RV32/RV64 base instruction word.
REQ-009 out_valid_o  output  1  head-of-FIFO result valid.
REQ-010 out_ready_i  input  1  consumer takes head result this cycle.
REQ-011 imm_o  output  XLEN  decoded immediate of head entry.
REQ-012 fmt_o  output  3  head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.

Function
REQ-013 Accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
REQ-014 Decode is combinational on instr_i; result written into FIFO on accept; visible on outputs no earlier than the next cycle (latency 1 when empty).
REQ-015 I-type (LOAD 0000011, JALR 1100111, OP-IMM 0010011 non-shift): imm = sign-ext instr[31:20], fmt 1.
REQ-016 SHAMT (OP-IMM funct3 001/101): imm = zero-ext instr[24:20] when XLEN=32, instr[25:20] when XLEN=64; fmt 6.
REQ-017 XLEN=64 only: OP-IMM-32 0011011 decodes as REQ-015/REQ-016 with shamt always instr[24:20]; when XLEN=32 this opcode is NONE.
REQ-018 S-type (0100011): imm = sign-ext {instr[31:25],instr[11:7]}, fmt 2.
REQ-019 B-type (1100011): imm = sign-ext {instr[31],instr[7],instr[30:25],instr[11:8],0}, fmt 3; bit 0 always 0.
REQ-020 U-type (LUI 0110111, AUIPC 0010111): imm = sign-ext {instr[31:12],12'h000}, fmt 4.
REQ-021 J-type (1101111): imm = sign-ext {instr[31],instr[19:12],instr[20],instr[30:21],0}, fmt 5.
REQ-022 Any other opcode: imm = 0, fmt 0.
REQ-023 Sign extension fills from instr[31] to bit XLEN-1.
REQ-024 FIFO order preserved; occupancy counter 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-025 in_ready_o = (count < DEPTH); no combinational path from out_ready_i to in_ready_o.
REQ-026 Full with pop in same cycle: no accept that cycle; in_ready_o rises next cycle.
REQ-027 Non-full with simultaneous accept and pop: count unchanged, both take effect.
REQ-028 out_valid_o = (count > 0); imm_o/fmt_o = 0 when empty.
REQ-029 flush_i priority over accept and pop: count and pointers to 0 next cycle; instruction presented that cycle is dropped.
REQ-030 Output payload stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-031 rst_n_i low: count, pointers cleared immediately; out_valid_o=0, imm_o=0, fmt_o=0, in_ready_o=1 (also illegal_o=0 when present).
REQ-032 Reset asserted mid-operation discards all queued results; deassertion takes effect at next rising edge.

Configuration
REQ-033 Macro IMM_GEN_ILLEGAL_EN defined: extra port illegal_o (output, 1) flags head entry whose opcode hit REQ-022 or whose instr[1:0] != 2'b11 (such entries forced to fmt 0, imm 0); stored per FIFO entry.
REQ-034 Macro undefined: no illegal_o port, no storage for it; instr[1:0] ignored; decode otherwise identical.

Verification
REQ-035 XLEN=32, DEPTH=2: push 0xFFF00093 (addi -1), out_ready_i=1 -> next cycle imm_o=0xFFFFFFFF, fmt_o=1.
REQ-036 Push 0xFE000EE3 (beq, offset -4) -> imm_o=0xFFFFFFFC, fmt_o=3; push 0x800000EF (jal) -> imm_o=0xFFF00000, fmt_o=5.
REQ-037 XLEN=64: push 0x03F01093 (slli shamt 63) -> imm_o=0x000000000000003F, fmt_o=6; push 0x800002B7 (lui) -> imm_o=0xFFFFFFFF80000000, fmt_o=4.
REQ-038 DEPTH=2, out_ready_i=0, push 3 back-to-back -> in_ready_o low after 2 accepts, third held; release out_ready_i -> results exit in order, third accepted the cycle after first pop.
REQ-039 Two entries queued, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, count 0, flushed-cycle instruction never appears.
REQ-040 IMM_GEN_ILLEGAL_EN defined: push 0x0000007F -> illegal_o=1, fmt_o=0, imm_o=0; rst_n_i pulsed low mid-stream -> out_valid_o=0 asynchronously.
